mvm_sequencer: RTL

MVM_SEQUENCER -- requirements
Module: mvm_sequencer

---
 rtl/mvm_pkg.sv | 19 +
 rtl/mvm_mac.sv | 40 ++++
 rtl/mvm_sequencer.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/mvm_pkg.sv
// Shared constants and types for the matrix-vector multiply sequencer.
// Widths are sized so that four products of a 4-bit signed coefficient and
// an 8-bit unsigned element can never overflow the accumulator.
package mvm_pkg;

    localparam int MVM_DIM = 4;   // matrix/vector dimension
    localparam int COEF_W  = 4;   // signed coefficient width (-8..7)
    localparam int ELEM_W  = 8;   // unsigned vector element width
    localparam int ACC_W   = 14;  // signed accumulator width (-8160..7140 fits)
    localparam int IDX_W   = 2;   // row/column/element index width
    localparam int ADDR_W  = 4;   // coefficient address width (row*4+col)

    typedef enum logic [1:0] {
        LOAD,
        COMPUTE,
        EMIT
    } state_t;

endpackage

// File: rtl/mvm_mac.sv
// One signed-coefficient x unsigned-element multiply-accumulate per enabled
// cycle. When clear is high the product starts a fresh sum instead of being
// added to the previous one.
module mvm_mac
    import mvm_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clear,
    input  logic [COEF_W-1:0] coef,
    input  logic [ELEM_W-1:0] elem,
    output logic [ACC_W-1:0]  acc
);

    logic signed [ACC_W-1:0] coef_ext;
    logic signed [ACC_W-1:0] elem_ext;
    logic signed [ACC_W-1:0] prod;
    logic signed [ACC_W-1:0] base;

    // Extend both operands to accumulator width and form the next partial sum.
    // NOTE: every variable gets a value on every path through always_comb, otherwise a latch is inferred.
    always_comb begin
        coef_ext = {{(ACC_W-COEF_W){coef[COEF_W-1]}}, coef};
        elem_ext = {{(ACC_W-ELEM_W){1'b0}}, elem};
        prod     = coef_ext * elem_ext;
        base     = clear ? '0 : $signed(acc);
    end

    // Accumulator register.
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (en) begin
            acc <= base + prod;
        end
    end

endmodule

// File: rtl/mvm_sequencer.sv
// Matrix-vector multiply sequencer: loads a 4-element unsigned vector,
// multiplies it by a 4x4 signed coefficient matrix one row at a time and
// streams one result per row through a valid/ready output.
// Each row takes four MAC cycles plus one write-back cycle, so out_valid
// rises five cycles after the edge that triggered the row.
// Optional feature: define MVM_SATURATE_EN to clamp results to OUT_W bits
// instead of wrapping them.
module mvm_sequencer
    import mvm_pkg::*;
#(
    parameter int DIM   = MVM_DIM,
    parameter int OUT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [3:0]       cfg_addr,
    input  logic [3:0]       cfg_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [1:0]       out_row,
    output logic             busy
);

    state_t             state;
    logic [IDX_W-1:0]   k;       // next vector slot to fill
    logic [IDX_W-1:0]   row;     // row being computed or emitted
    logic [IDX_W-1:0]   col;     // column fed to the MAC this cycle
    logic               drain;   // all four columns issued, accumulator final
    logic [ELEM_W-1:0]  vec  [DIM];
    logic [COEF_W-1:0]  coef [DIM*DIM];

    logic               mac_en;
    logic               mac_clr;
    logic [COEF_W-1:0]  mac_coef;
    logic [ELEM_W-1:0]  mac_elem;
    logic [ACC_W-1:0]   acc;
    logic [OUT_W-1:0]   result;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIM - 1);

    assign in_ready = (state == LOAD);
    assign busy     = (state != LOAD);

    // Feed the MAC with the current row/column operands while columns remain.
    always_comb begin
        mac_en   = (state == COMPUTE) && !drain;
        mac_clr  = (col == '0);
        mac_coef = coef[{row, col}];
        mac_elem = vec[col];
    end

    mvm_mac u_mac (
        .clk   (clk),
        .rst   (rst),
        .en    (mac_en),
        .clear (mac_clr),
        .coef  (mac_coef),
        .elem  (mac_elem),
        .acc   (acc)
    );

`ifdef MVM_SATURATE_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 <<< (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(1 <<< (OUT_W - 1)));

    // Clamp the finished row sum into the signed OUT_W range.
    always_comb begin
        if ($signed(acc) > SAT_MAX) begin
            result = OUT_W'(SAT_MAX);
        end else if ($signed(acc) < SAT_MIN) begin
            result = OUT_W'(SAT_MIN);
        end else begin
            result = OUT_W'($signed(acc));
        end
    end
`else
    // Keep the low OUT_W bits of the finished row sum (two's-complement wrap).
    always_comb begin
        result = OUT_W'($signed(acc));
    end
`endif

    // Sequencer FSM with coefficient/vector storage and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= LOAD;
            k         <= '0;
            row       <= '0;
            col       <= '0;
            drain     <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_row   <= '0;
            // NOTE: these small register arrays are reset because a reset must leave an all-zero matrix and vector.
            for (int i = 0; i < DIM; i++) begin
                vec[i] <= '0;
            end
            for (int i = 0; i < DIM*DIM; i++) begin
                coef[i] <= '0;
            end
        end else begin
            case (state)
                LOAD: begin
                    // A write on the same edge as the 4th accept lands before
                    // the first MAC cycle reads the matrix.
                    if (cfg_we) begin
                        coef[cfg_addr] <= cfg_data;
                    end
                    if (in_valid) begin
                        vec[k] <= in_data;
                        k      <= k + IDX_W'(1);
                        if (k == LAST_IDX) begin
                            state <= COMPUTE;
                            row   <= '0;
                            col   <= '0;
                            drain <= 1'b0;
                        end
                    end
                end

                COMPUTE: begin
                    if (!drain) begin
                        col <= col + IDX_W'(1);
                        if (col == LAST_IDX) begin
                            drain <= 1'b1;
                        end
                    end else begin
                        drain     <= 1'b0;
                        state     <= EMIT;
                        out_valid <= 1'b1;
                        out_data  <= result;
                        out_row   <= row;
                    end
                end

                EMIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (row == LAST_IDX) begin
                            state <= LOAD;
                            row   <= '0;
                        end else begin
                            state <= COMPUTE;
                            row   <= row + IDX_W'(1);
                        end
                    end
                end

                default: begin
                    state <= LOAD;
                end
            endcase
        end
    end

endmodule
